ram_arbiter_ctrl: RTL and testbench

//   Sequences the asynchronous SRAM chip (active-low CS/WE/OE, shared bidirectional data bus) from the clocked domain.

---
 rtl/ram_arbiter_ctrl.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter_ctrl.sv
// Two-port round-robin arbiter and strobe sequencer for an asynchronous SRAM.
// Every SRAM-facing signal comes straight from a flop, so strobes are glitch-free.
module ram_arbiter_ctrl #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned ACCESS_CYC = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              A_Req,
  input  logic              A_We,
  input  logic [ADDR_W-1:0] A_Addr,
  input  logic [DATA_W-1:0] A_WData,
  output logic              A_Ack,
  input  logic              B_Req,
  input  logic              B_We,
  input  logic [ADDR_W-1:0] B_Addr,
  input  logic [DATA_W-1:0] B_WData,
  output logic              B_Ack,
  output logic [DATA_W-1:0] RData,
  output logic              Busy,
  output logic [ADDR_W-1:0] Ram_Addr,
  inout  wire  [DATA_W-1:0] Ram_Data,
  output logic              Ram_CS_n,
  output logic              Ram_WE_n,
  output logic              Ram_OE_n
);

  localparam int unsigned MAX_CYC = (SETUP_CYC > ACCESS_CYC) ? SETUP_CYC : ACCESS_CYC;
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SETUP  = 3'd1;
  localparam logic [2:0] STROBE = 3'd2;
  localparam logic [2:0] HOLD   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              gnt_b_q, gnt_b_d;
  logic              last_b_q, last_b_d;
  logic              cs_n_q, cs_n_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              drv_q, drv_d;
  logic              a_ack_q, a_ack_d;
  logic              b_ack_q, b_ack_d;
  logic              busy_q, busy_d;
  logic              take_b;
  logic              on_bus;

  // Next-state, grant and phase counter; outputs are decoded from the next state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    gnt_b_d  = gnt_b_q;
    last_b_d = last_b_q;
    take_b   = 1'b0;

    case (state_q)
      IDLE: begin
        if (A_Req || B_Req) begin
          take_b   = B_Req && (!A_Req || !last_b_q);
          gnt_b_d  = take_b;
          last_b_d = take_b;
          we_d     = take_b ? B_We    : A_We;
          addr_d   = take_b ? B_Addr  : A_Addr;
          wdata_d  = take_b ? B_WData : A_WData;
          state_d  = SETUP;
          cnt_d    = CNT_W'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = CNT_W'(ACCESS_CYC - 1);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = '0;
          if (!we_q) rdata_d = Ram_Data;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        state_d = DONE;
        cnt_d   = '0;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    on_bus  = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
    cs_n_d  = !on_bus;
    we_n_d  = !((state_d == STROBE) && we_d);
    oe_n_d  = !((state_d == STROBE) && !we_d);
    drv_d   = on_bus && we_d;
    a_ack_d = (state_d == DONE) && !gnt_b_d;
    b_ack_d = (state_d == DONE) && gnt_b_d;
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      addr_q   <= '0;
      rdata_q  <= '0;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      cs_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      drv_q    <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      addr_q   <= addr_d;
      rdata_q  <= rdata_d;
      gnt_b_q  <= gnt_b_d;
      last_b_q <= last_b_d;
      cs_n_q   <= cs_n_d;
      we_n_q   <= we_n_d;
      oe_n_q   <= oe_n_d;
      drv_q    <= drv_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      busy_q   <= busy_d;
    end
  end

  assign Ram_Data = drv_q ? wdata_q : {DATA_W{1'bz}};
  assign Ram_Addr = addr_q;
  assign Ram_CS_n = cs_n_q;
  assign Ram_WE_n = we_n_q;
  assign Ram_OE_n = oe_n_q;
  assign RData    = rdata_q;
  assign A_Ack    = a_ack_q;
  assign B_Ack    = b_ack_q;
  assign Busy     = busy_q;

endmodule

// File: tb/tb_ram_arbiter_ctrl.sv
// Bench for ram_arbiter_ctrl: SRAM model, ack scoreboard, invariant monitor and a
// second instance with stretched setup/access timing.
module tb_ram_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
  logic [15:0] a_addr = '0, b_addr = '0;
  logic [7:0]  a_wdata = '0, b_wdata = '0;
  logic        a_ack, b_ack, busy, ram_cs_n, ram_we_n, ram_oe_n;
  logic [7:0]  rdata;
  logic [15:0] ram_addr;
  wire  [7:0]  ram_data;

  logic        a2_req = 0, a2_we = 0;
  logic [15:0] a2_addr = '0;
  logic [7:0]  a2_wdata = '0;
  logic        a2_ack, b2_ack, busy2, cs2_n, we2_n, oe2_n;
  logic [7:0]  rdata2;
  logic [15:0] ram2_addr;
  wire  [7:0]  ram2_data;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    bit         port_b;
    bit         chk_rdata;
    logic [7:0] rdata;
    int         cyc;
  } sb_t;
  sb_t sb_q[$];

  logic [7:0] mem [0:65535];

  ram_arbiter_ctrl u_dut (
    .Clk(clk), .Rst(rst),
    .A_Req(a_req), .A_We(a_we), .A_Addr(a_addr), .A_WData(a_wdata), .A_Ack(a_ack),
    .B_Req(b_req), .B_We(b_we), .B_Addr(b_addr), .B_WData(b_wdata), .B_Ack(b_ack),
    .RData(rdata), .Busy(busy), .Ram_Addr(ram_addr), .Ram_Data(ram_data),
    .Ram_CS_n(ram_cs_n), .Ram_WE_n(ram_we_n), .Ram_OE_n(ram_oe_n)
  );

  ram_arbiter_ctrl #(.ADDR_W(16), .DATA_W(8), .SETUP_CYC(2), .ACCESS_CYC(3)) u_dut2 (
    .Clk(clk), .Rst(rst),
    .A_Req(a2_req), .A_We(a2_we), .A_Addr(a2_addr), .A_WData(a2_wdata), .A_Ack(a2_ack),
    .B_Req(1'b0), .B_We(1'b0), .B_Addr(16'h0000), .B_WData(8'h00), .B_Ack(b2_ack),
    .RData(rdata2), .Busy(busy2), .Ram_Addr(ram2_addr), .Ram_Data(ram2_data),
    .Ram_CS_n(cs2_n), .Ram_WE_n(we2_n), .Ram_OE_n(oe2_n)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;

  // Asynchronous SRAM models: main array, and a fixed-pattern device for the slow instance
  always @(posedge clk) if (!ram_cs_n && !ram_we_n) mem[ram_addr] <= ram_data;
  assign ram_data  = (!ram_cs_n && !ram_oe_n) ? mem[ram_addr] : 8'hzz;
  assign ram2_data = (!cs2_n && !oe2_n) ? 8'h3C : 8'hzz;

  // Ack scoreboard
  always @(negedge clk) begin
    if (a_ack || b_ack) begin
      if (sb_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_ack a=%0b b=%0b cyc=%0d", a_ack, b_ack, cyc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        vectors++;
        if ({a_ack, b_ack} !== (e.port_b ? 2'b01 : 2'b10)) begin
          miscompares++;
          $display("FAIL ack_port got a=%0b b=%0b expected port_b=%0b", a_ack, b_ack, e.port_b);
        end
        vectors++;
        if (cyc !== e.cyc) begin
          miscompares++;
          $display("FAIL ack_cycle got %0d expected %0d", cyc, e.cyc);
        end
        if (e.chk_rdata) begin
          vectors++;
          if (rdata !== e.rdata) begin
            miscompares++;
            $display("FAIL rdata got %h expected %h", rdata, e.rdata);
          end
        end
      end
    end
  end

  // Strobe invariants on both instances, every cycle
  always @(negedge clk) begin
    vectors++;
    if (!ram_we_n && !ram_oe_n) begin
      miscompares++;
      $display("FAIL we_oe_overlap dut1 cyc=%0d", cyc);
    end
    vectors++;
    if (!we2_n && !oe2_n) begin
      miscompares++;
      $display("FAIL we_oe_overlap dut2 cyc=%0d", cyc);
    end
    if (!ram_oe_n) begin
      vectors++;
      if (ram_data !== mem[ram_addr]) begin
        miscompares++;
        $display("FAIL bus_contention got %h expected %h", ram_data, mem[ram_addr]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input bit pb, input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pb ? b_ack : a_ack) seen = 1'b1;
    end
  endtask

  task automatic do_access(input bit pb, input bit we, input logic [15:0] addr,
                           input logic [7:0] wd, input logic [7:0] exp_rd);
    bit  seen;
    sb_t e;
    @(negedge clk);
    if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wd; end
    else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wd; end
    e.port_b = pb; e.chk_rdata = !we; e.rdata = exp_rd; e.cyc = cyc + 5;
    sb_q.push_back(e);
    wait_ack(pb, 20, seen);
    if (pb) b_req = 0; else a_req = 0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL access_ack_timeout port_b=%0b addr=%h", pb, addr);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    bit  seen;
    sb_t e;
    a_req = 1; a_we = 1; a_addr = 16'h0002; a_wdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if ({ram_cs_n, ram_we_n, ram_oe_n} !== 3'b111) begin
        miscompares++;
        $display("FAIL reset_strobes got %b expected 111", {ram_cs_n, ram_we_n, ram_oe_n});
      end
      vectors++;
      if (ram_data === 8'h77) begin
        miscompares++;
        $display("FAIL reset_data_driven got %h expected z", ram_data);
      end
      vectors++;
      if ({busy, ram_addr, rdata} !== 25'd0) begin
        miscompares++;
        $display("FAIL reset_regs got busy=%b addr=%h rdata=%h expected 0", busy, ram_addr, rdata);
      end
    end
    rst = 0;
    e.port_b = 0; e.chk_rdata = 0; e.rdata = '0; e.cyc = cyc + 5;
    sb_q.push_back(e);
    wait_ack(1'b0, 20, seen);
    a_req = 0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL reset_first_access ack not seen, expected A_Ack");
    end
  endtask

  task automatic test_write_read();
    do_access(1'b0, 1'b1, 16'h1234, 8'hA5, 8'h00);
    do_access(1'b0, 1'b0, 16'h1234, 8'h00, 8'hA5);
    do_access(1'b0, 1'b1, 16'hFFFF, 8'h96, 8'h00);
    do_access(1'b0, 1'b0, 16'hFFFF, 8'h00, 8'h96);
    do_access(1'b0, 1'b0, 16'h0002, 8'h00, 8'h77);
  endtask

  task automatic test_b_port();
    do_access(1'b1, 1'b1, 16'h00FF, 8'h3C, 8'h00);
    do_access(1'b1, 1'b0, 16'h00FF, 8'h00, 8'h3C);
    do_access(1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5);
  endtask

  task automatic test_round_robin();
    sb_t e;
    int  d, acks;
    apply_reset();
    @(negedge clk);
    d = cyc;
    a_req = 1; a_we = 0; a_addr = 16'h1234;
    b_req = 1; b_we = 1; b_addr = 16'h0020; b_wdata = 8'h11;
    for (int k = 0; k < 4; k++) begin
      e.port_b = (k % 2) == 1; e.chk_rdata = (k % 2) == 0; e.rdata = 8'hA5;
      e.cyc = d + 5 + 6 * k;
      sb_q.push_back(e);
    end
    acks = 0;
    for (int i = 0; i < 40 && acks < 4; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) acks++;
      if (cyc == d + 6 || cyc == d + 12 || cyc == d + 18) begin
        vectors++;
        if (ram_cs_n !== 1'b1) begin
          miscompares++;
          $display("FAIL rr_gap_cs_n got %b expected 1 cyc=%0d", ram_cs_n, cyc);
        end
      end
    end
    a_req = 0; b_req = 0;
    vectors++;
    if (acks != 4) begin
      miscompares++;
      $display("FAIL rr_ack_count got %0d expected 4", acks);
    end
  endtask

  task automatic test_req_drop();
    bit  seen;
    sb_t e;
    @(negedge clk);
    a_req = 1; a_we = 0; a_addr = 16'h0020;
    e.port_b = 0; e.chk_rdata = 1; e.rdata = 8'h11; e.cyc = cyc + 5;
    sb_q.push_back(e);
    @(negedge clk);
    a_req = 0; a_addr = 16'h1234; a_we = 1;
    wait_ack(1'b0, 20, seen);
    a_we = 0;
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL req_drop ack not seen, expected A_Ack");
    end
  endtask

  task automatic test_timing();
    int d, cs_lo, oe_lo, we_lo, ack_cyc;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      d = cyc;
      a2_req = 1; a2_we = (pass == 1); a2_addr = 16'h0400; a2_wdata = 8'hC3;
      cs_lo = 0; oe_lo = 0; we_lo = 0; ack_cyc = -1;
      for (int i = 0; i < 14; i++) begin
        @(negedge clk);
        if (!cs2_n) cs_lo++;
        if (!oe2_n) oe_lo++;
        if (!we2_n) we_lo++;
        if (a2_ack && ack_cyc < 0) begin
          ack_cyc = cyc;
          a2_req = 0;
        end
      end
      a2_req = 0;
      vectors++;
      if (cs_lo != 6) begin
        miscompares++;
        $display("FAIL t2_cs_low pass=%0d got %0d expected 6", pass, cs_lo);
      end
      vectors++;
      if (oe_lo != (pass == 0 ? 3 : 0) || we_lo != (pass == 1 ? 3 : 0)) begin
        miscompares++;
        $display("FAIL t2_strobe_len pass=%0d got oe=%0d we=%0d", pass, oe_lo, we_lo);
      end
      vectors++;
      if (ack_cyc != d + 7) begin
        miscompares++;
        $display("FAIL t2_ack_cycle pass=%0d got %0d expected %0d", pass, ack_cyc, d + 7);
      end
      vectors++;
      if (rdata2 !== 8'h3C) begin
        miscompares++;
        $display("FAIL t2_rdata got %h expected 3c", rdata2);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bit seen;
    @(negedge clk);
    b_req = 1; b_we = 1; b_addr = 16'h0010; b_wdata = 8'h5A;
    @(negedge clk);
    vectors++;
    if (ram_cs_n !== 1'b0 || ram_we_n !== 1'b1 || ram_data !== 8'h5A) begin
      miscompares++;
      $display("FAIL mid_setup got cs=%b we=%b data=%h expected 0 1 5a", ram_cs_n, ram_we_n, ram_data);
    end
    @(negedge clk);
    vectors++;
    if (ram_we_n !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_strobe_we got %b expected 0", ram_we_n);
    end
    rst = 1;
    @(negedge clk);
    b_req = 0;
    vectors++;
    if ({ram_cs_n, ram_we_n, ram_oe_n, busy} !== 4'b1110 || ram_data === 8'h5A) begin
      miscompares++;
      $display("FAIL mid_reset got cs=%b we=%b oe=%b busy=%b data=%h expected 1 1 1 0 z",
               ram_cs_n, ram_we_n, ram_oe_n, busy, ram_data);
    end
    @(negedge clk);
    rst = 0;
    wait_ack(1'b1, 10, seen);
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL mid_reset_ack got B_Ack expected none");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_b_port();
    test_round_robin();
    test_req_drop();
    test_timing();
    test_reset_mid_access();
    repeat (3) @(negedge clk);
    vectors++;
    if (sb_q.size() != 0) begin
      miscompares++;
      $display("FAIL sb_leftover got %0d expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
